// File: rtl/shift_pkg.sv
// Shared mode encodings for the universal shift register.
package shift_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;
    localparam logic [MODE_W-1:0] MODE_SIPO = 3'b110;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b111;

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts captured SIPO bits and emits a registered one-cycle pulse when a
// full WIDTH-bit word has been assembled.
module sipo_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     clr,
    output logic                     wrap,
    output logic [$clog2(WIDTH)-1:0] count
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q, count_d;
    logic          wrap_q, wrap_d;

    // Next count: clear wins, otherwise step and wrap on the last bit.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Count and wrap pulse registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign wrap  = wrap_q;
    assign count = count_q;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: chunked shifts/rotates, arithmetic shift,
// parallel load and counted single-bit SIPO capture with word-valid strobe.
module shift_reg_universal
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIN_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [SIN_W-1:0]  serial_in,
    input  logic [WIDTH-1:0]  parallel_in,
    output logic [WIDTH-1:0]  parallel_out,
    output logic [SIN_W-1:0]  serial_out,
    output logic              word_valid
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [SIN_W-1:0] sout_q, sout_d;
    logic             sipo_inc;
    logic             cnt_clr;
    logic [$clog2(WIDTH)-1:0] unused_bit_cnt;

    // Operation decode; any enabled non-SIPO cycle discards a partial word.
    always_comb begin
        q_d      = q_q;
        sout_d   = sout_q;
        sipo_inc = 1'b0;
        cnt_clr  = 1'b0;
        if (en) begin
            sipo_inc = (mode == MODE_SIPO);
            cnt_clr  = (mode != MODE_SIPO);
            case (mode)
                MODE_HOLD: ;
                MODE_SHR: begin
                    q_d    = {serial_in, q_q[WIDTH-1:SIN_W]};
                    sout_d = q_q[SIN_W-1:0];
                end
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-1-SIN_W:0], serial_in};
                    sout_d = q_q[WIDTH-1 -: SIN_W];
                end
                MODE_ROR: begin
                    q_d    = {q_q[SIN_W-1:0], q_q[WIDTH-1:SIN_W]};
                    sout_d = q_q[SIN_W-1:0];
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-1-SIN_W:0], q_q[WIDTH-1 -: SIN_W]};
                    sout_d = q_q[WIDTH-1 -: SIN_W];
                end
                MODE_LOAD: q_d = parallel_in;
                MODE_SIPO: q_d = {q_q[WIDTH-2:0], serial_in[SIN_W-1]};
                MODE_ASR: begin
                    q_d    = {{SIN_W{q_q[WIDTH-1]}}, q_q[WIDTH-1:SIN_W]};
                    sout_d = q_q[SIN_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Data and serial-out registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            sout_q <= '0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
        end
    end

    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sipo_inc),
        .clr   (cnt_clr),
        .wrap  (word_valid),
        .count (unused_bit_cnt)
    );

    assign parallel_out = q_q;
    assign serial_out   = sout_q;

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised successor to the team's 8-bit select-driven shift/load block.
- Holds an internal WIDTH-bit register and operates on it every cycle. Supported operations: multi-bit shift left/right, rotate, arithmetic shift, parallel load and a counted single-bit serial-in/parallel-out (SIPO) capture with a word-valid strobe.
- Sits between serial front-end logic and parallel datapath consumers in the miniproject datapath.

Parameters:
- WIDTH, 8, register width in bits; must be at least 2.
- SIN_W, 3, serial chunk width consumed/emitted per shift; 1 <= SIN_W < WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; low means hold.
- mode  input  3  operation select (encodings below).
- serial_in  input  SIN_W  serial chunk fed into the register.
- parallel_in  input  WIDTH  parallel load value.
- parallel_out  output  WIDTH  current register contents (registered).
- serial_out  output  SIN_W  chunk shifted out by the last shift (registered).
- word_valid  output  1  one-cycle pulse when a full SIPO word is assembled.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset low clears immediately).
- Reset values: q=0, parallel_out=0, serial_out=0, word_valid=0, bit_cnt=0. Reset asserted mid-operation aborts any SIPO capture with no valid pulse.
- parallel_out is q; all updates occur at the clk rising edge when en=1.
- en=0: q, serial_out and bit_cnt hold; word_valid=0.
- Mode encodings (en=1):
  - 000 HOLD: q unchanged; word_valid=0.
  - 001 SHR: q <= {serial_in, q[WIDTH-1:SIN_W]}; serial_out <= q[SIN_W-1:0].
  - 010 SHL: q <= {q[WIDTH-1-SIN_W:0], serial_in}; serial_out <= q[WIDTH-1 -: SIN_W].
  - 011 ROR: q rotated right by SIN_W; serial_out <= q[SIN_W-1:0].
  - 100 ROL: q rotated left by SIN_W; serial_out <= q[WIDTH-1 -: SIN_W].
  - 101 LOAD: q <= parallel_in; serial_out unchanged.
  - 110 SIPO: q <= {q[WIDTH-2:0], serial_in[SIN_W-1]} (MSB of the chunk only); bit_cnt increments.
    - When bit_cnt == WIDTH-1 at the edge: bit_cnt wraps to 0 and word_valid=1 in the following cycle, with parallel_out holding the completed word in that same cycle.
  - 111 ASR: q <= {{SIN_W{q[WIDTH-1]}}, q[WIDTH-1:SIN_W]}; serial_out <= q[SIN_W-1:0].
- Mode change: any cycle with en=1 and mode != 110 clears bit_cnt to 0, so a partial SIPO word is discarded.
- en=0 during SIPO pauses the capture; bit_cnt is retained.
- word_valid: high for exactly one cycle per completed word. Back-to-back words pulse every WIDTH enabled SIPO cycles.
- Latency: one cycle from the sampling edge to the output for every mode.
- Mode and parallel_in are sampled only at the edge; no combinational input-to-output paths.
- No X assignment; all eight encodings are defined.
- bit_cnt width: $clog2(WIDTH).

Decomposition:
- Shared package shift_pkg holds:
  - localparams for the mode encodings: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_LOAD, MODE_SIPO, MODE_ASR;
  - the mode width constant (3).
- One natural sub-module: sipo_bit_counter (WIDTH parameter).
  - Inputs: clk, reset, inc, clr.
  - Outputs: wrap pulse and count.
  - Instantiated once; drives word_valid.

Test Plan (WIDTH=8, SIN_W=3):
- Reset and load: reset low, then LOAD 8'hA5 → parallel_out=00 during reset, A5 one cycle after the LOAD edge; serial_out=0.
- Shift right: from A5, SHR with serial_in=3'b110 → parallel_out=8'hD4, serial_out=3'b101. Then SHL with serial_in=3'b011 → 8'hA3, serial_out=3'b110.
- Rotate and ASR:
  - From 8'h81: ROR → 8'h30, serial_out=3'b001.
  - From 8'h81: ROL → 8'h0C, serial_out=3'b100.
  - From 8'h90: ASR → 8'hF2, serial_out=3'b000.
- SIPO word: LOAD 00, then 8 SIPO cycles with serial_in MSBs 1,0,1,1,0,0,1,0 → parallel_out=8'hB2 and word_valid=1 for exactly one cycle after the 8th edge. A ninth SIPO cycle does not pulse.
- SIPO pause and abort:
  - en=0 for 3 cycles after bit 4 → count held; the pulse still arrives after 8 enabled cycles.
  - Switching to HOLD after bit 5, then restarting SIPO → the pulse requires 8 fresh bits.
- Async reset mid-SIPO: assert reset between edges after bit 6 → outputs clear immediately; the next 8 SIPO bits give a single pulse.
